// File: rtl/ascii_add_pkg.sv
// Shared types and character constants for the ASCII decimal adder.
package ascii_add_pkg;

    typedef enum logic [2:0] {
        LOAD_A,
        LOAD_B,
        ADD,
        SEND,
        FAULT
    } state_t;

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_NINE  = 8'h39;
    localparam logic [7:0] ASCII_FAULT = 8'h3F;

    typedef logic [3:0] bcd_t;

endpackage

// File: rtl/bcd_digit_add.sv
// One BCD digit adder with decimal carry correction.
module bcd_digit_add
    import ascii_add_pkg::*;
(
    input  bcd_t a,
    input  bcd_t b,
    input  logic cin,
    output bcd_t sum,
    output logic cout
);

    logic [4:0] raw;

    assign raw  = {1'b0, a} + {1'b0, b} + {4'b0, cin};
    assign cout = (raw > 5'd9);
    assign sum  = cout ? (raw[3:0] + 4'd6) : raw[3:0];

endmodule

// File: rtl/ascii_add_ctrl.sv
// Serial ASCII decimal adder: two ND-digit operands in, ND+1 digits out.
// Define ASCII_ADD_ZERO_SUPPRESS_EN to drop leading '0' characters on output.
module ascii_add_ctrl
    import ascii_add_pkg::*;
#(
    parameter int ND = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] DIN,
    input  logic       DIN_VALID,
    output logic       DIN_READY,
    output logic [7:0] DOUT,
    output logic       DOUT_VALID,
    input  logic       DOUT_READY,
    output logic       BUSY,
    output logic       ERR
);

    localparam int CW = $clog2(ND + 1);

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   lead_q, lz, sel, wi;
    bcd_t            a_dig [ND];
    bcd_t            b_dig [ND];
    bcd_t            r_dig [ND+1];
    logic            carry_q, err_q;
    logic            accept, take, din_ok, cin, cout;
    logic            add_last, send_last;
    bcd_t            din_bcd, sum;

    assign accept    = DIN_VALID && DIN_READY;
    assign take      = DOUT_VALID && DOUT_READY;
    assign din_ok    = (DIN >= ASCII_ZERO) && (DIN <= ASCII_NINE);
    assign din_bcd   = 4'(DIN - ASCII_ZERO);
    assign wi        = CW'(ND - 1) - cnt_q;
    assign sel       = CW'(ND) - cnt_q - lead_q;
    assign cin       = (cnt_q == '0) ? 1'b0 : carry_q;
    assign add_last  = (cnt_q == CW'(ND - 1));
    assign send_last = ((cnt_q + lead_q) == CW'(ND));
    assign ERR       = err_q;

    bcd_digit_add u_add (
        .a    (a_dig[cnt_q]),
        .b    (b_dig[cnt_q]),
        .cin  (cin),
        .sum  (sum),
        .cout (cout)
    );

`ifdef ASCII_ADD_ZERO_SUPPRESS_EN
    bcd_t full [ND+1];
    logic done;

    // Digit 0 is never counted, so at least one character is always sent.
    always_comb begin
        for (int i = 0; i < ND + 1; i++) full[i] = r_dig[i];
        full[ND-1] = sum;
        full[ND]   = {3'b0, cout};
        lz   = '0;
        done = 1'b0;
        for (int i = ND; i >= 1; i--) begin
            if (!done && full[i] == 4'd0) lz = lz + CW'(1);
            else done = 1'b1;
        end
    end
`else
    assign lz = '0;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= LOAD_A;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        DIN_READY  = 1'b0;
        DOUT_VALID = 1'b0;
        DOUT       = 8'h00;
        BUSY       = !(state_q == LOAD_A && cnt_q == '0);
        unique case (state_q)
            LOAD_A, LOAD_B: begin
                DIN_READY = 1'b1;
                if (accept) begin
                    if (!din_ok) begin
                        state_d = FAULT;
                        cnt_d   = '0;
                    end else if (cnt_q == CW'(ND - 1)) begin
                        state_d = (state_q == LOAD_A) ? LOAD_B : ADD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            ADD: begin
                if (add_last) begin
                    state_d = SEND;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            SEND: begin
                DOUT_VALID = 1'b1;
                DOUT       = {4'h0, r_dig[sel]} + ASCII_ZERO;
                if (take) begin
                    if (send_last) begin
                        state_d = LOAD_A;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            FAULT: begin
                DOUT_VALID = 1'b1;
                DOUT       = ASCII_FAULT;
                if (take) begin
                    state_d = LOAD_A;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = LOAD_A;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < ND; i++) begin
                a_dig[i] <= '0;
                b_dig[i] <= '0;
            end
            for (int i = 0; i < ND + 1; i++) r_dig[i] <= '0;
            carry_q <= 1'b0;
            lead_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= accept && !din_ok;
            if (accept && !din_ok) begin
                for (int i = 0; i < ND; i++) begin
                    a_dig[i] <= '0;
                    b_dig[i] <= '0;
                end
                for (int i = 0; i < ND + 1; i++) r_dig[i] <= '0;
            end else if (accept && state_q == LOAD_A) begin
                a_dig[wi] <= din_bcd;
            end else if (accept && state_q == LOAD_B) begin
                b_dig[wi] <= din_bcd;
            end
            if (state_q == ADD) begin
                r_dig[cnt_q] <= sum;
                carry_q      <= cout;
                if (add_last) begin
                    r_dig[ND] <= {3'b0, cout};
                    lead_q    <= lz;
                end
            end
        end
    end

endmodule

// File: tb/tb_ascii_add_ctrl.sv
// Directed bench for ascii_add_ctrl with ND=2.
module tb_ascii_add_ctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [7:0] DIN = 8'h00;
    logic       DIN_VALID = 1'b0;
    logic       DIN_READY;
    logic [7:0] DOUT;
    logic       DOUT_VALID;
    logic       DOUT_READY = 1'b0;
    logic       BUSY;
    logic       ERR;

    int total = 0;
    int bad   = 0;

    ascii_add_ctrl #(.ND(2)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .DIN        (DIN),
        .DIN_VALID  (DIN_VALID),
        .DIN_READY  (DIN_READY),
        .DOUT       (DOUT),
        .DOUT_VALID (DOUT_VALID),
        .DOUT_READY (DOUT_READY),
        .BUSY       (BUSY),
        .ERR        (ERR)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic put(input byte c);
        int n = 0;
        @(negedge CLK);
        DIN       = c;
        DIN_VALID = 1'b1;
        while (!DIN_READY && n < 50) begin
            @(negedge CLK);
            n++;
        end
        chk("din_ready_wait", {31'b0, DIN_READY}, 32'd1);
        @(posedge CLK);
        #1;
        DIN_VALID = 1'b0;
        chk("err", {31'b0, ERR},
            {31'b0, !(c >= "0" && c <= "9")});
    endtask

    task automatic get(input string tag, input byte exp);
        int n = 0;
        @(negedge CLK);
        DOUT_READY = 1'b1;
        while (!DOUT_VALID && n < 50) begin
            @(negedge CLK);
            n++;
        end
        chk({tag, "_valid"}, {31'b0, DOUT_VALID}, 32'd1);
        chk(tag, {24'b0, DOUT}, {24'b0, exp});
        @(posedge CLK);
        #1;
        DOUT_READY = 1'b0;
    endtask

    task automatic run_add(input string tag, input string a,
                           input string b, input string exp);
        for (int i = 0; i < a.len(); i++) put(a[i]);
        for (int i = 0; i < b.len(); i++) put(b[i]);
        for (int i = 0; i < exp.len(); i++) get(tag, exp[i]);
        @(negedge CLK);
        chk({tag, "_idle"}, {31'b0, BUSY}, 32'd0);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_rdy"},   {31'b0, DIN_READY},  32'd1);
        chk({tag, "_dout"},  {24'b0, DOUT},       32'h00);
        chk({tag, "_dv"},    {31'b0, DOUT_VALID}, 32'd0);
        chk({tag, "_busy"},  {31'b0, BUSY},       32'd0);
        chk({tag, "_err"},   {31'b0, ERR},        32'd0);
    endtask

    initial begin
        int   pat [4] = '{1, 0, 0, 1};
        byte  got [$];
        byte  prev;
        bit   hold;
        int   k;

        // reset state
        #12;
        chk_reset("rst");
        @(negedge CLK);
        RST = 1'b0;

        // basic add, plus BUSY after the first character
        put("4");
        chk("busy_mid", {31'b0, BUSY}, 32'd1);
        put("7");
        run_add("add4785", "", "85", "132");

        // all-nines with latency check
        put("9"); put("9"); put("9"); put("9");
        @(negedge CLK);
        chk("lat1", {31'b0, DOUT_VALID}, 32'd0);
        chk("lat1_rdy", {31'b0, DIN_READY}, 32'd0);
        @(negedge CLK);
        chk("lat2", {31'b0, DOUT_VALID}, 32'd0);
        @(negedge CLK);
        chk("lat3", {31'b0, DOUT_VALID}, 32'd1);
        run_add("add9999", "", "", "198");

        // invalid character, then a clean transaction
        put("4");
        put("A");
        chk("fault_rdy", {31'b0, DIN_READY}, 32'd0);
        get("fault", "?");
        @(negedge CLK);
        chk("fault_idle", {31'b0, BUSY}, 32'd0);
        chk("fault_err_gone", {31'b0, ERR}, 32'd0);
        run_add("add1234", "12", "34", "046");

        // leading zeros
`ifdef ASCII_ADD_ZERO_SUPPRESS_EN
        run_add("add0102", "01", "02", "3");
`else
        run_add("add0102", "01", "02", "003");
`endif

        // downstream backpressure 1,0,0,1
        put("4"); put("7"); put("8"); put("5");
        hold = 1'b0;
        prev = 8'h00;
        k = 0;
        while (got.size() < 3 && k < 60) begin
            @(negedge CLK);
            if (hold) chk("hold", {24'b0, DOUT}, {24'b0, prev});
            DOUT_READY = pat[k % 4][0];
            k++;
            if (DOUT_VALID && DOUT_READY) got.push_back(DOUT);
            hold = DOUT_VALID && !DOUT_READY;
            prev = DOUT;
        end
        @(posedge CLK);
        #1;
        DOUT_READY = 1'b0;
        chk("bp_count", got.size(), 32'd3);
        if (got.size() > 0) chk("bp_c0", {24'b0, got[0]}, {24'b0, 8'h31});
        if (got.size() > 1) chk("bp_c1", {24'b0, got[1]}, {24'b0, 8'h33});
        if (got.size() > 2) chk("bp_c2", {24'b0, got[2]}, {24'b0, 8'h32});
        @(negedge CLK);
        chk("bp_idle", {31'b0, BUSY}, 32'd0);

        // reset mid-operand
        put("1"); put("2"); put("3");
        @(negedge CLK);
        RST = 1'b1;
        #1;
        chk_reset("rst_mid");
        #1;
        RST = 1'b0;
        run_add("add1020", "10", "20", "030");

        // reset mid-send
        put("9"); put("9"); put("9"); put("9");
        get("pre_rst", "1");
        @(negedge CLK);
        RST = 1'b1;
        #1;
        chk_reset("rst_send");
        #1;
        RST = 1'b0;
        run_add("add4785b", "47", "85", "132");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
